// File: rtl/reg_file_if.sv
// reg_file_if: bundle of the read, writeback and issue/scoreboard signals
// between the CARP decode/writeback logic (master) and reg_file (slave).
//
// Handshake semantics: none. Every signal is sampled on every rising edge.
// There is no valid/ready pairing. WE and ISSUE_EN are per-cycle strobes
// that the master holds low when idle. RS*_DATA and RS*_BUSY are
// combinational responses to the current RS*_ADDR.
interface reg_file_if #(
    parameter int XLEN = 32
);
    logic [4:0]      RS1_ADDR;
    logic [4:0]      RS2_ADDR;
    logic [XLEN-1:0] RS1_DATA;
    logic [XLEN-1:0] RS2_DATA;
    logic            WE;
    logic [4:0]      WA;
    logic [XLEN-1:0] WD;
    logic            ISSUE_EN;
    logic [4:0]      ISSUE_RD;
    logic            CLR_PEND;
    logic            RS1_BUSY;
    logic            RS2_BUSY;

    modport master (
        output RS1_ADDR, RS2_ADDR, WE, WA, WD, ISSUE_EN, ISSUE_RD, CLR_PEND,
        input  RS1_DATA, RS2_DATA, RS1_BUSY, RS2_BUSY
    );

    modport slave (
        input  RS1_ADDR, RS2_ADDR, WE, WA, WD, ISSUE_EN, ISSUE_RD, CLR_PEND,
        output RS1_DATA, RS2_DATA, RS1_BUSY, RS2_BUSY
    );
endinterface

// File: rtl/reg_file.sv
// reg_file: RV32I integer register file with a per-register pending-write
// scoreboard for read-after-write stall detection.
// - Two combinational read ports, one synchronous write port.
// - x0 is not stored: it reads 0, ignores writes and is never pending.
// - Optional macro REG_FILE_BYPASS_EN selects write-first bypass. A read of
//   the register being written this cycle returns WD, and its BUSY is
//   cleared. With the macro undefined, the old value and BUSY are seen
//   until the write edge.
// - Reset is synchronous and active-low. It overrides any same-edge write,
//   issue or flush.
module reg_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic       CLK,
    input  logic       RST_N,
    reg_file_if.slave  bus
);

    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic            wr_en;
    logic            iss_en;

    assign wr_en  = bus.WE && (bus.WA != 5'd0);
    assign iss_en = bus.ISSUE_EN && (bus.ISSUE_RD != 5'd0);

    // Scoreboard next state. Later assignments take priority:
    // flush > issue > writeback > hold.
    always_comb begin
        pend_d = pend_q;
        if (wr_en) begin
            pend_d[bus.WA] = 1'b0;
        end
        if (iss_en) begin
            pend_d[bus.ISSUE_RD] = 1'b1;
        end
        if (bus.CLR_PEND) begin
            pend_d = '0;
        end
        pend_d[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Register storage. Writes commit even during a flush.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[bus.WA] <= bus.WD;
        end
    end

    // Read port 1 data and busy, with optional write-first bypass.
    always_comb begin
        bus.RS1_DATA = '0;
        bus.RS1_BUSY = 1'b0;
        if (bus.RS1_ADDR != 5'd0) begin
            bus.RS1_DATA = regs_q[bus.RS1_ADDR];
            bus.RS1_BUSY = pend_q[bus.RS1_ADDR];
        end
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && (bus.WA == bus.RS1_ADDR)) begin
            bus.RS1_DATA = bus.WD;
            bus.RS1_BUSY = 1'b0;
        end
`endif
    end

    // Read port 2 data and busy, with optional write-first bypass.
    always_comb begin
        bus.RS2_DATA = '0;
        bus.RS2_BUSY = 1'b0;
        if (bus.RS2_ADDR != 5'd0) begin
            bus.RS2_DATA = regs_q[bus.RS2_ADDR];
            bus.RS2_BUSY = pend_q[bus.RS2_ADDR];
        end
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && (bus.WA == bus.RS2_ADDR)) begin
            bus.RS2_DATA = bus.WD;
            bus.RS2_BUSY = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file.
// Inputs change 1 time unit after each rising edge and are checked 3 units
// after the edge, so checks happen well away from the active edge.
module tb_reg_file;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    reg_file_if #(.XLEN(32)) bus ();

    reg_file #(.XLEN(32), .NREG(32)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog timer.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.WE       = 1'b0;
        bus.WA       = 5'd0;
        bus.WD       = '0;
        bus.ISSUE_EN = 1'b0;
        bus.ISSUE_RD = 5'd0;
        bus.CLR_PEND = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] a;
        logic [4:0] b;
        idle_inputs();
        bus.RS1_ADDR = 5'd0;
        bus.RS2_ADDR = 5'd0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a = 5'(i);
            b = 5'(31 - i);
            bus.RS1_ADDR = a;
            bus.RS2_ADDR = b;
            #1;
            tests_run++;
            if (bus.RS1_DATA !== 32'h0 || bus.RS2_DATA !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_data idx=%0d got rs1=%h rs2=%h want 0", i, bus.RS1_DATA, bus.RS2_DATA);
            end
            tests_run++;
            if (bus.RS1_BUSY !== 1'b0 || bus.RS2_BUSY !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_busy idx=%0d got b1=%b b2=%b want 0", i, bus.RS1_BUSY, bus.RS2_BUSY);
            end
        end
    endtask

    task automatic test_write();
        tick();
        bus.WE = 1'b1; bus.WA = 5'd5; bus.WD = 32'hDEADBEEF;
        tick();
        bus.WE = 1'b1; bus.WA = 5'd0; bus.WD = 32'hFFFFFFFF;
        tick();
        bus.WE = 1'b1; bus.WA = 5'd31; bus.WD = 32'h00000001;
        tick();
        bus.WE = 1'b1; bus.WA = 5'd1; bus.WD = 32'h80000000;
        tick();
        idle_inputs();
        bus.RS1_ADDR = 5'd5;
        bus.RS2_ADDR = 5'd0;
        #2;
        tests_run++;
        if (bus.RS1_DATA !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL write_x5 got %h want deadbeef", bus.RS1_DATA);
        end
        tests_run++;
        if (bus.RS2_DATA !== 32'h0) begin
            tests_failed++;
            $display("FAIL write_x0 got %h want 00000000", bus.RS2_DATA);
        end
        bus.RS1_ADDR = 5'd31;
        bus.RS2_ADDR = 5'd1;
        #1;
        tests_run++;
        if (bus.RS1_DATA !== 32'h00000001) begin
            tests_failed++;
            $display("FAIL write_x31 got %h want 00000001", bus.RS1_DATA);
        end
        tests_run++;
        if (bus.RS2_DATA !== 32'h80000000) begin
            tests_failed++;
            $display("FAIL write_x1 got %h want 80000000", bus.RS2_DATA);
        end
        tests_run++;
        if (bus.RS1_BUSY !== 1'b0 || bus.RS2_BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_not_pending_busy got b1=%b b2=%b want 0", bus.RS1_BUSY, bus.RS2_BUSY);
        end
    endtask

    task automatic test_pending();
        tick();
        bus.ISSUE_EN = 1'b1; bus.ISSUE_RD = 5'd7;
        bus.RS1_ADDR = 5'd7;
        bus.RS2_ADDR = 5'd6;
        #2;
        tests_run++;
        if (bus.RS1_BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL pend_issue_cycle got %b want 0", bus.RS1_BUSY);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            idle_inputs();
            #2;
            tests_run++;
            if (bus.RS1_BUSY !== 1'b1 || bus.RS1_DATA !== 32'h0) begin
                tests_failed++;
                $display("FAIL pend_hold cyc=%0d got busy=%b data=%h want 1/0", c, bus.RS1_BUSY, bus.RS1_DATA);
            end
            tests_run++;
            if (bus.RS2_BUSY !== 1'b0) begin
                tests_failed++;
                $display("FAIL pend_neighbor x6 got %b want 0", bus.RS2_BUSY);
            end
        end
        tick();
        bus.WE = 1'b1; bus.WA = 5'd7; bus.WD = 32'h12345678;
        #2;
`ifdef REG_FILE_BYPASS_EN
        tests_run++;
        if (bus.RS1_BUSY !== 1'b0 || bus.RS1_DATA !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL pend_wb_cycle got busy=%b data=%h want 0/12345678", bus.RS1_BUSY, bus.RS1_DATA);
        end
`else
        tests_run++;
        if (bus.RS1_BUSY !== 1'b1 || bus.RS1_DATA !== 32'h0) begin
            tests_failed++;
            $display("FAIL pend_wb_cycle got busy=%b data=%h want 1/00000000", bus.RS1_BUSY, bus.RS1_DATA);
        end
`endif
        tick();
        idle_inputs();
        #2;
        tests_run++;
        if (bus.RS1_BUSY !== 1'b0 || bus.RS1_DATA !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL pend_after_wb got busy=%b data=%h want 0/12345678", bus.RS1_BUSY, bus.RS1_DATA);
        end
    endtask

    task automatic test_issue_wb_same();
        tick();
        bus.ISSUE_EN = 1'b1; bus.ISSUE_RD = 5'd9;
        bus.WE = 1'b1; bus.WA = 5'd9; bus.WD = 32'h99990000;
        tick();
        idle_inputs();
        bus.RS1_ADDR = 5'd0;
        bus.RS2_ADDR = 5'd9;
        #2;
        tests_run++;
        if (bus.RS2_BUSY !== 1'b1) begin
            tests_failed++;
            $display("FAIL issue_wins_busy got %b want 1", bus.RS2_BUSY);
        end
        tests_run++;
        if (bus.RS2_DATA !== 32'h99990000) begin
            tests_failed++;
            $display("FAIL issue_wins_data got %h want 99990000", bus.RS2_DATA);
        end
        tick();
        bus.ISSUE_EN = 1'b1; bus.ISSUE_RD = 5'd0;
        tick();
        idle_inputs();
        bus.RS1_ADDR = 5'd0;
        #2;
        tests_run++;
        if (bus.RS1_BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL issue_x0_busy got %b want 0", bus.RS1_BUSY);
        end
        tick();
        bus.WE = 1'b1; bus.WA = 5'd9; bus.WD = 32'h00000009;
        tick();
        idle_inputs();
        #2;
        tests_run++;
        if (bus.RS2_BUSY !== 1'b0 || bus.RS2_DATA !== 32'h00000009) begin
            tests_failed++;
            $display("FAIL wb_clears_x9 got busy=%b data=%h want 0/00000009", bus.RS2_BUSY, bus.RS2_DATA);
        end
    endtask

    task automatic test_clear();
        tick();
        bus.ISSUE_EN = 1'b1; bus.ISSUE_RD = 5'd3;
        tick();
        bus.ISSUE_RD = 5'd4;
        tick();
        bus.ISSUE_RD = 5'd10;
        tick();
        idle_inputs();
        bus.RS1_ADDR = 5'd3;
        bus.RS2_ADDR = 5'd10;
        #2;
        tests_run++;
        if (bus.RS1_BUSY !== 1'b1 || bus.RS2_BUSY !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_pre got b1=%b b2=%b want 1/1", bus.RS1_BUSY, bus.RS2_BUSY);
        end
        tick();
        bus.CLR_PEND = 1'b1;
        bus.ISSUE_EN = 1'b1; bus.ISSUE_RD = 5'd11;
        bus.WE = 1'b1; bus.WA = 5'd3; bus.WD = 32'h00000033;
        tick();
        idle_inputs();
        bus.RS1_ADDR = 5'd3;
        bus.RS2_ADDR = 5'd4;
        #2;
        tests_run++;
        if (bus.RS1_BUSY !== 1'b0 || bus.RS2_BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_x3_x4 got b1=%b b2=%b want 0/0", bus.RS1_BUSY, bus.RS2_BUSY);
        end
        tests_run++;
        if (bus.RS1_DATA !== 32'h00000033) begin
            tests_failed++;
            $display("FAIL clear_wb_commits got %h want 00000033", bus.RS1_DATA);
        end
        bus.RS1_ADDR = 5'd10;
        bus.RS2_ADDR = 5'd11;
        #1;
        tests_run++;
        if (bus.RS1_BUSY !== 1'b0 || bus.RS2_BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_x10_x11 got b1=%b b2=%b want 0/0", bus.RS1_BUSY, bus.RS2_BUSY);
        end
    endtask

    task automatic test_reset_write();
        tick();
        rst_n = 1'b0;
        bus.WE = 1'b1; bus.WA = 5'd12; bus.WD = 32'hA5A5A5A5;
        bus.ISSUE_EN = 1'b1; bus.ISSUE_RD = 5'd13;
        tick();
        rst_n = 1'b1;
        idle_inputs();
        bus.RS1_ADDR = 5'd12;
        bus.RS2_ADDR = 5'd13;
        #2;
        tests_run++;
        if (bus.RS1_DATA !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_drops_write got %h want 00000000", bus.RS1_DATA);
        end
        tests_run++;
        if (bus.RS2_BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_drops_issue got %b want 0", bus.RS2_BUSY);
        end
        bus.RS1_ADDR = 5'd5;
        bus.RS2_ADDR = 5'd31;
        #1;
        tests_run++;
        if (bus.RS1_DATA !== 32'h0 || bus.RS2_DATA !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_clears_regs got x5=%h x31=%h want 0/0", bus.RS1_DATA, bus.RS2_DATA);
        end
    endtask

    // Test sequence and summary.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        idle_inputs();
        bus.RS1_ADDR = 5'd0;
        bus.RS2_ADDR = 5'd0;
        test_reset();
        test_write();
        test_pending();
        test_issue_wb_same();
        test_clear();
        test_reset_write();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
